// File: rtl/apb_pkg.sv
// Shared types and field widths for the APB requester and the apb_slave benches.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int unsigned APB_STRB_W = 4;
  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 8;
  localparam int unsigned APB_WAIT_W = 8;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the APB requester: counts stalled ACCESS cycles and
// flags the cycle on which the LIMIT-th consecutive stall is seen.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic stall_i,
  output logic expired_o
);

  localparam logic [APB_WAIT_W-1:0] LAST = APB_WAIT_W'(LIMIT - 1);

  logic [APB_WAIT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (stall_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the stalls already seen, so this stall is the LIMIT-th one.
  assign expired_o = stall_i && (count_q == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: one command in, one SETUP/ACCESS transfer out, one response pulse back.
// Define APB_MASTER_TIMEOUT_EN to abort transfers stalled for TIMEOUT_CYCLES ACCESS cycles.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Command side: accepted on a cycle where cmd_valid && cmd_ready.
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [WIDTH-1:0]      cmd_wdata,
  input  logic [APB_STRB_W-1:0] cmd_strb,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  output logic [WIDTH-1:0]      pwdata,
  output logic [APB_STRB_W-1:0] pstrb,
  input  logic [WIDTH-1:0]      prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output apb_state_t            dbg_state
);

  apb_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [WIDTH-1:0]      pwdata_q, pwdata_d;
  logic [APB_STRB_W-1:0] pstrb_q, pstrb_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_wait_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (state_q == SETUP),
    .stall_i  ((state_q == ACCESS) && !pready),
    .expired_o(timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          pstrb_d  = cmd_write ? cmd_strb : '0;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // A ready slave wins over a timer expiring in the same cycle.
        if (pready) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
        end else if (timeout_hit) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule
